// File: rtl/rr_merge_pkg.sv
// Shared port-addressing definitions for the 1-to-4 router and the 4-to-1 merge.
package rr_merge_pkg;
  localparam int NUM_PORTS = 4;
  localparam int PORT_AW   = 2;

  typedef logic [PORT_AW-1:0] port_addr_t;
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter4
  import rr_merge_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  port_addr_t           ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output port_addr_t           gnt_idx,
  output logic                 any_gnt
);

  port_addr_t cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      // Natural 2-bit wrap gives the ptr, ptr+1, ... mod 4 search order.
      cand = ptr + port_addr_t'(k);
      if (!any_gnt && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        any_gnt   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_merge4.sv
// Four-to-one round-robin merge with a single registered output slot tagged by source.
module rr_merge4
  import rr_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] din3,
  input  logic                  din0_en,
  input  logic                  din1_en,
  input  logic                  din2_en,
  input  logic                  din3_en,
  output logic                  din0_rdy,
  output logic                  din1_rdy,
  output logic                  din2_rdy,
  output logic                  din3_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_en,
  output port_addr_t            dout_addr,
  input  logic                  dout_rdy
);

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  port_addr_t            addr_q, addr_d;
  logic                  en_q, en_d;
  port_addr_t            ptr_q, ptr_d;

  logic [NUM_PORTS-1:0]  req, gnt;
  port_addr_t            gnt_idx;
  logic                  any_gnt;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_data;

  assign req = {din3_en, din2_en, din1_en, din0_en};

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Slot can take a new word when empty or when its current word leaves this cycle.
  assign load = !en_q || dout_rdy;

  // Gating with resetn keeps every accept strobe low while reset is held.
  assign din0_rdy = resetn && load && gnt[0];
  assign din1_rdy = resetn && load && gnt[1];
  assign din2_rdy = resetn && load && gnt[2];
  assign din3_rdy = resetn && load && gnt[3];

  always_comb begin
    case (gnt_idx)
      2'd0:    sel_data = din0;
      2'd1:    sel_data = din1;
      2'd2:    sel_data = din2;
      default: sel_data = din3;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    addr_d = addr_q;
    en_d   = en_q;
    ptr_d  = ptr_q;
    if (load) begin
      if (any_gnt) begin
        dout_d = sel_data;
        addr_d = gnt_idx;
        en_d   = 1'b1;
        ptr_d  = gnt_idx + port_addr_t'(1);
      end else begin
        // Empty slot always presents zero data and address.
        dout_d = '0;
        addr_d = '0;
        en_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q <= '0;
      addr_q <= '0;
      en_q   <= 1'b0;
      ptr_q  <= '0;
    end else begin
      dout_q <= dout_d;
      addr_q <= addr_d;
      en_q   <= en_d;
      ptr_q  <= ptr_d;
    end
  end

  assign dout      = dout_q;
  assign dout_addr = addr_q;
  assign dout_en   = en_q;

endmodule
